// File: rtl/log_mult_pipe.sv
// Pipelined Mitchell logarithmic multiplier: operand capture, log conversion,
// log add and antilog by shift, with a global valid/ready stall and a sideband tag.
module log_mult_pipe #(
    parameter int W     = 16,
    parameter int TRUNC = 0,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_sgn,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out_p,
    output logic             out_sgn,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero
);

    localparam int KW = $clog2(W);
    localparam int FW = W - 1;
    localparam int LW = KW + W;
    localparam logic [KW-1:0]  FW_K       = KW'(FW);
    localparam logic [KW:0]    FW_KS      = (KW+1)'(FW);
    localparam logic [FW-1:0]  TRUNC_MASK = {FW{1'b1}} << TRUNC;

    function automatic logic [W-1:0] magnitude(input logic [W-1:0] x, input logic sgn);
        if (sgn && x[W-1]) begin
            magnitude = -x;
        end else begin
            magnitude = x;
        end
    endfunction

    function automatic logic [KW-1:0] lead_one(input logic [W-1:0] x);
        lead_one = '0;
        for (int i = 0; i < W; i++) begin
            if (x[i]) begin
                lead_one = KW'(i);
            end
        end
    endfunction

    logic             en_s;
    logic             v0_q, sgn0_q;
    logic [W-1:0]     a0_q, b0_q;
    logic [TAG_W-1:0] tag0_q;

    logic             v1_q, neg1_q, zero1_q, sgn1_q;
    logic [KW-1:0]    ka1_q, kb1_q;
    logic [FW-1:0]    fa1_q, fb1_q;
    logic [TAG_W-1:0] tag1_q;

    logic             v2_q, neg2_q, zero2_q, sgn2_q;
    logic [KW:0]      ks2_q;
    logic [FW-1:0]    fs2_q;
    logic [TAG_W-1:0] tag2_q;

    logic             out_valid_q, out_sgn_q, out_zero_q;
    logic [2*W-1:0]   out_p_q;
    logic [TAG_W-1:0] out_tag_q;

    logic [W-1:0]     mag_a_d, mag_b_d;
    logic [KW-1:0]    ka_d, kb_d;
    logic [FW-1:0]    fa_d, fb_d;
    logic             neg_d, zero_d;
    logic [LW-1:0]    l_d;
    logic [2*W-1:0]   m_d, mag_d, p_d;

    assign en_s     = ~out_valid_q | out_ready;
    assign in_ready = en_s;

    // Stage 1: magnitude, leading-one position and normalised (truncated) fraction
    always_comb begin
        mag_a_d = magnitude(a0_q, sgn0_q);
        mag_b_d = magnitude(b0_q, sgn0_q);
        ka_d    = lead_one(mag_a_d);
        kb_d    = lead_one(mag_b_d);
        fa_d    = FW'(mag_a_d << (FW_K - ka_d)) & TRUNC_MASK;
        fb_d    = FW'(mag_b_d << (FW_K - kb_d)) & TRUNC_MASK;
        neg_d   = sgn0_q & (a0_q[W-1] ^ b0_q[W-1]);
        zero_d  = (mag_a_d == '0) | (mag_b_d == '0);
    end

    // Stage 2: log add; the fraction carry ripples into the characteristic
    always_comb begin
        l_d = LW'({ka1_q, fa1_q}) + LW'({kb1_q, fb1_q});
    end

    // Stage 3: antilog by shifting the restored mantissa, then apply sign and zero
    always_comb begin
        m_d   = {{W{1'b0}}, 1'b1, fs2_q};
        mag_d = '0;
        p_d   = '0;
        if (ks2_q >= FW_KS) begin
            mag_d = m_d << (ks2_q - FW_KS);
        end else begin
            mag_d = m_d >> (FW_KS - ks2_q);
        end
        if (zero2_q) begin
            p_d = '0;
        end else if (neg2_q) begin
            p_d = -mag_d;
        end else begin
            p_d = mag_d;
        end
    end

    // Pipeline registers; every rank advances together only when the output can move
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0_q        <= 1'b0;
            sgn0_q      <= 1'b0;
            a0_q        <= '0;
            b0_q        <= '0;
            tag0_q      <= '0;
            v1_q        <= 1'b0;
            neg1_q      <= 1'b0;
            zero1_q     <= 1'b0;
            sgn1_q      <= 1'b0;
            ka1_q       <= '0;
            kb1_q       <= '0;
            fa1_q       <= '0;
            fb1_q       <= '0;
            tag1_q      <= '0;
            v2_q        <= 1'b0;
            neg2_q      <= 1'b0;
            zero2_q     <= 1'b0;
            sgn2_q      <= 1'b0;
            ks2_q       <= '0;
            fs2_q       <= '0;
            tag2_q      <= '0;
            out_valid_q <= 1'b0;
            out_sgn_q   <= 1'b0;
            out_zero_q  <= 1'b0;
            out_p_q     <= '0;
            out_tag_q   <= '0;
        end else if (en_s) begin
            v0_q        <= in_valid;
            sgn0_q      <= in_sgn;
            a0_q        <= in_a;
            b0_q        <= in_b;
            tag0_q      <= in_tag;
            v1_q        <= v0_q;
            neg1_q      <= neg_d;
            zero1_q     <= zero_d;
            sgn1_q      <= sgn0_q;
            ka1_q       <= ka_d;
            kb1_q       <= kb_d;
            fa1_q       <= fa_d;
            fb1_q       <= fb_d;
            tag1_q      <= tag0_q;
            v2_q        <= v1_q;
            neg2_q      <= neg1_q;
            zero2_q     <= zero1_q;
            sgn2_q      <= sgn1_q;
            ks2_q       <= l_d[LW-1:FW];
            fs2_q       <= l_d[FW-1:0];
            tag2_q      <= tag1_q;
            out_valid_q <= v2_q;
            out_sgn_q   <= sgn2_q;
            out_zero_q  <= zero2_q;
            out_p_q     <= p_d;
            out_tag_q   <= tag2_q;
        end else begin
            out_valid_q <= out_valid_q;
        end
    end

    assign out_valid = out_valid_q;
    assign out_p     = out_p_q;
    assign out_sgn   = out_sgn_q;
    assign out_tag   = out_tag_q;
    assign out_zero  = out_zero_q;

endmodule
